// File: rtl/tia_pkg.sv
// tia_pkg: shared constants and types for the TIA horizontal-motion block.
//   HM_W        width of each motion register / sequence counter
//   NUM_OBJ     number of movable objects (P0, P1, M0, M1, BL)
//   HM_SEQ_LEN  number of motion ticks in one HMOVE sequence
//   obj_e       object index, also the bit position in per-object vectors
//   hm_state_e  motion sequencer states
package tia_pkg;

  localparam int HM_W       = 4;
  localparam int NUM_OBJ    = 5;
  localparam int HM_SEQ_LEN = 15;

  typedef enum logic [2:0] {
    P0 = 3'd0,
    P1 = 3'd1,
    M0 = 3'd2,
    M1 = 3'd3,
    BL = 3'd4
  } obj_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } hm_state_e;

  // True on the tick where an object's extra clocks run out. The compare
  // value ~(hm ^ 8) equals 15 - N, where N = hm ^ 8 is the pulse count,
  // so the object stops after exactly N ticks of a down-counting sequence.
  function automatic logic hm_stop(input logic [HM_W-1:0] cnt,
                                   input logic [HM_W-1:0] hm);
    return cnt == ~(hm ^ 4'b1000);
  endfunction

endpackage

// File: rtl/tia_horizontal_motion_if.sv
// tia_horizontal_motion_if: register-write and timing strobes feeding the
// horizontal-motion block.
//   d          motion value (data bus D7..D4)
//   p0hm..blhm per-object motion register write strobes
//   hmove      start a motion sequence
//   hmclr      clear all motion registers
//   mot_tick   motion tick, one per 4 colour clocks
// Modports: master drives the strobes, slave (the motion block) receives.
interface tia_horizontal_motion_if;

  logic [3:0] d;
  logic       p0hm;
  logic       p1hm;
  logic       m0hm;
  logic       m1hm;
  logic       blhm;
  logic       hmove;
  logic       hmclr;
  logic       mot_tick;

  modport master (
    output d, p0hm, p1hm, m0hm, m1hm, blhm, hmove, hmclr, mot_tick
  );

  modport slave (
    input d, p0hm, p1hm, m0hm, m1hm, blhm, hmove, hmclr, mot_tick
  );

endinterface

// File: rtl/tia_motion_compare.sv
// tia_motion_compare: one object's motion slice -- enable flag, stop
// comparator and registered extra-clock pulse.
//   clk       phi2 clock
//   reset     synchronous active-high reset
//   start     hmove strobe: re-arms the enable
//   run_tick  motion tick accepted by the sequencer (RUN, no hmove)
//   cnt       live sequence counter
//   hm        live motion register of this object
//   ec        one-cycle extra-clock pulse, cycle after the tick
module tia_motion_compare
  import tia_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            run_tick,
  input  logic [HM_W-1:0] cnt,
  input  logic [HM_W-1:0] hm,
  output logic            ec
);

  logic en_r;
  logic stop_s;

  assign stop_s = hm_stop(cnt, hm);

  // Enable flag and registered pulse; a matching tick drops the enable
  // and suppresses its own pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_r <= 1'b0;
      ec   <= 1'b0;
    end else begin
      if (start) begin
        en_r <= 1'b1;
      end else if (run_tick && stop_s) begin
        en_r <= 1'b0;
      end else begin
        en_r <= en_r;
      end
      ec <= run_tick && en_r && !stop_s;
    end
  end

endmodule

// File: rtl/tia_horizontal_motion.sv
// tia_horizontal_motion: TIA HMOVE sequencer. Holds the five 4-bit motion
// registers and, after an hmove, issues hm^8 extra-clock pulses per object
// over 15 motion ticks.
//   phi2          clock
//   reset         synchronous active-high reset
//   bus           strobe interface (slave modport)
//   p0ec..blec    registered extra-clock pulses to position counters
//   hmove_active  high while the sequence runs
//   hmove_blank   late-HBLANK comb, only when TIA_HMOVE_BLANK_EN is defined
module tia_horizontal_motion
  import tia_pkg::*;
(
  input  logic                    phi2,
  input  logic                    reset,
  tia_horizontal_motion_if.slave  bus,
  output logic                    p0ec,
  output logic                    p1ec,
  output logic                    m0ec,
  output logic                    m1ec,
  output logic                    blec,
  output logic                    hmove_active
`ifdef TIA_HMOVE_BLANK_EN
  ,
  output logic                    hmove_blank
`endif
);

  logic [NUM_OBJ-1:0] wr_s;
  logic [HM_W-1:0]    hm_r [NUM_OBJ];
  hm_state_e          state_r;
  hm_state_e          state_s;
  logic [HM_W-1:0]    cnt_r;
  logic [HM_W-1:0]    cnt_s;
  logic               run_tick_s;
  logic [NUM_OBJ-1:0] ec_s;

  assign wr_s = {bus.blhm, bus.m1hm, bus.m0hm, bus.p1hm, bus.p0hm};

  // Motion registers; hmclr beats any coincident write.
  always_ff @(posedge phi2) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) hm_r[i] <= 4'd0;
    end else if (bus.hmclr) begin
      for (int i = 0; i < NUM_OBJ; i++) hm_r[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (wr_s[i]) hm_r[i] <= bus.d;
        else         hm_r[i] <= hm_r[i];
      end
    end
  end

  // Sequencer state and counter registers.
  always_ff @(posedge phi2) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state: hmove (re)starts from any state and swallows a coincident
  // tick; the tick taken at cnt==1 is the last one of the sequence.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (bus.hmove) begin
      state_s = RUN;
      cnt_s   = 4'(HM_SEQ_LEN);
    end else if ((state_r == RUN) && bus.mot_tick) begin
      if (cnt_r == 4'd1) begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end else begin
        cnt_s   = cnt_r - 4'd1;
      end
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  assign run_tick_s   = (state_r == RUN) && bus.mot_tick && !bus.hmove;
  assign hmove_active = (state_r == RUN);

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    tia_motion_compare u_cmp (
      .clk      (phi2),
      .reset    (reset),
      .start    (bus.hmove),
      .run_tick (run_tick_s),
      .cnt      (cnt_r),
      .hm       (hm_r[g]),
      .ec       (ec_s[g])
    );
  end

  assign p0ec = ec_s[P0];
  assign p1ec = ec_s[P1];
  assign m0ec = ec_s[M0];
  assign m1ec = ec_s[M1];
  assign blec = ec_s[BL];

`ifdef TIA_HMOVE_BLANK_EN
  logic       blank_r;
  logic [1:0] blank_ticks_r;

  // Blank comb: set by hmove, dropped by the second tick that follows.
  always_ff @(posedge phi2) begin
    if (reset) begin
      blank_r       <= 1'b0;
      blank_ticks_r <= 2'd0;
    end else if (bus.hmove) begin
      blank_r       <= 1'b1;
      blank_ticks_r <= 2'd0;
    end else if (blank_r && bus.mot_tick) begin
      if (blank_ticks_r == 2'd1) begin
        blank_r       <= 1'b0;
        blank_ticks_r <= 2'd0;
      end else begin
        blank_ticks_r <= blank_ticks_r + 2'd1;
      end
    end else begin
      blank_r       <= blank_r;
      blank_ticks_r <= blank_ticks_r;
    end
  end

  assign hmove_blank = blank_r;
`endif

endmodule

// File: tb/tb_tia_horizontal_motion.sv
// Self-checking bench for tia_horizontal_motion with a tick-level reference model.
module tb_tia_horizontal_motion;

  logic phi2 = 1'b0;
  logic reset = 1'b1;
  always #5 phi2 = ~phi2;

  tia_horizontal_motion_if bus();

  logic p0ec, p1ec, m0ec, m1ec, blec, hmove_active;
  logic [4:0] ec_v;
  assign ec_v = {blec, m1ec, m0ec, p1ec, p0ec};
`ifdef TIA_HMOVE_BLANK_EN
  logic hmove_blank;
`endif

  tia_horizontal_motion dut (
    .phi2         (phi2),
    .reset        (reset),
    .bus          (bus),
    .p0ec         (p0ec),
    .p1ec         (p1ec),
    .m0ec         (m0ec),
    .m1ec         (m1ec),
    .blec         (blec),
    .hmove_active (hmove_active)
`ifdef TIA_HMOVE_BLANK_EN
    ,
    .hmove_blank  (hmove_blank)
`endif
  );

  int checks = 0;
  int failures = 0;
  int mism = 0;

  // Reference model: sequence position, live motion values, stop flags.
  bit         run_m = 1'b0;
  int         k_m = 0;
  logic [3:0] hm_m [5];
  bit         stop_m [5];
  logic [4:0] exp_ec = 5'd0;
  int         exp_tot [5];
  int         obs_tot [5];
  bit         blank_m = 1'b0;
  int         bt_m = 0;

  task automatic clear_tot();
    for (int i = 0; i < 5; i++) begin
      exp_tot[i] = 0;
      obs_tot[i] = 0;
    end
    mism = 0;
  endtask

  task automatic step(input logic [4:0] w, input logic [3:0] dv, input bit hmv,
                      input bit clr, input bit tk, input bit rs);
    logic [4:0] nx;
    int n;
    bus.d = dv;
    bus.p0hm = w[0]; bus.p1hm = w[1]; bus.m0hm = w[2]; bus.m1hm = w[3]; bus.blhm = w[4];
    bus.hmove = hmv; bus.hmclr = clr; bus.mot_tick = tk;
    reset = rs;
    @(posedge phi2);
    nx = 5'd0;
    if (rs) begin
      run_m = 1'b0; k_m = 0; blank_m = 1'b0; bt_m = 0;
      for (int i = 0; i < 5; i++) begin hm_m[i] = 4'd0; stop_m[i] = 1'b0; end
    end else begin
      if (hmv) begin
        run_m = 1'b1; k_m = 0;
        for (int i = 0; i < 5; i++) stop_m[i] = 1'b0;
      end else if (run_m && tk) begin
        k_m++;
        for (int i = 0; i < 5; i++) begin
          n = int'(hm_m[i] ^ 4'b1000);
          if (k_m == n + 1) stop_m[i] = 1'b1;
          else if (!stop_m[i]) nx[i] = 1'b1;
        end
        if (k_m == 15) run_m = 1'b0;
      end
      if (hmv) begin
        blank_m = 1'b1; bt_m = 0;
      end else if (blank_m && tk) begin
        bt_m++;
        if (bt_m == 2) blank_m = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        if (clr) hm_m[i] = 4'd0;
        else if (w[i]) hm_m[i] = dv;
      end
    end
    exp_ec = nx;
    for (int i = 0; i < 5; i++) exp_tot[i] += int'(nx[i]);
    #1;
    if (ec_v !== exp_ec) mism++;
    if (hmove_active !== run_m) mism++;
`ifdef TIA_HMOVE_BLANK_EN
    if (hmove_blank !== blank_m) mism++;
`endif
    for (int i = 0; i < 5; i++) obs_tot[i] += int'(ec_v[i]);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    idle(int'($urandom_range(1, 3)));
    step(5'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic hmove();
    step(5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ec_v !== 5'd0) begin failures++; $display("FAIL reset_ec got=%b exp=%b", ec_v, 5'd0); end
    checks++;
    if (hmove_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", hmove_active); end
    idle(2);
  endtask

  task automatic test_all_zero();
    clear_tot();
    hmove();
    for (int t = 0; t < 14; t++) tick();
    checks++;
    if (hmove_active !== 1'b1) begin failures++; $display("FAIL zero_active14 got=%b exp=1", hmove_active); end
    tick();
    checks++;
    if (hmove_active !== 1'b0) begin failures++; $display("FAIL zero_active15 got=%b exp=0", hmove_active); end
    idle(3);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_tot[i] !== 8) begin failures++; $display("FAIL zero_count obj=%0d got=%0d exp=8", i, obs_tot[i]); end
    end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL zero_cycle mismatches=%0d exp=0", mism); end
  endtask

  task automatic test_extremes();
    clear_tot();
    step(5'b00001, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'b01000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    hmove();
    for (int t = 0; t < 15; t++) tick();
    idle(3);
    checks++;
    if (obs_tot[0] !== 15) begin failures++; $display("FAIL ext_p0 got=%0d exp=15", obs_tot[0]); end
    checks++;
    if (obs_tot[3] !== 0) begin failures++; $display("FAIL ext_m1 got=%0d exp=0", obs_tot[3]); end
    checks++;
    if ((obs_tot[1] !== 8) || (obs_tot[2] !== 8) || (obs_tot[4] !== 8)) begin
      failures++;
      $display("FAIL ext_others got=%0d,%0d,%0d exp=8", obs_tot[1], obs_tot[2], obs_tot[4]);
    end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL ext_cycle mismatches=%0d exp=0", mism); end
  endtask

  task automatic test_hmclr_mid();
    clear_tot();
    step(5'b00001, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    hmove();
    for (int t = 0; t < 5; t++) tick();
    idle(1);
    step(5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++) tick();
    idle(3);
    checks++;
    if (obs_tot[0] !== 8) begin failures++; $display("FAIL hmclr_p0 got=%0d exp=8", obs_tot[0]); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL hmclr_cycle mismatches=%0d exp=0", mism); end
  endtask

  task automatic test_restart();
    clear_tot();
    hmove();
    for (int t = 0; t < 6; t++) tick();
    hmove();
    for (int t = 0; t < 14; t++) tick();
    checks++;
    if (hmove_active !== 1'b1) begin failures++; $display("FAIL restart_active got=%b exp=1", hmove_active); end
    tick();
    idle(2);
    checks++;
    if (obs_tot[2] !== 14) begin failures++; $display("FAIL restart_m0 got=%0d exp=14", obs_tot[2]); end
    clear_tot();
    hmove();
    for (int t = 0; t < 3; t++) tick();
    idle(1);
    step(5'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ec_v !== 5'd0) begin failures++; $display("FAIL coincide_ec got=%b exp=%b", ec_v, 5'd0); end
    for (int t = 0; t < 14; t++) tick();
    checks++;
    if (hmove_active !== 1'b1) begin failures++; $display("FAIL coincide_active got=%b exp=1", hmove_active); end
    tick();
    checks++;
    if (hmove_active !== 1'b0) begin failures++; $display("FAIL coincide_end got=%b exp=0", hmove_active); end
    idle(2);
    checks++;
    if (obs_tot[4] !== 11) begin failures++; $display("FAIL coincide_bl got=%0d exp=11", obs_tot[4]); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL restart_cycle mismatches=%0d exp=0", mism); end
  endtask

  task automatic test_reset_mid();
    int sum;
    clear_tot();
    step(5'b11111, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    hmove();
    for (int t = 0; t < 2; t++) tick();
    idle(1);
    step(5'b11111, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ((ec_v !== 5'd0) || (hmove_active !== 1'b0)) begin
      failures++;
      $display("FAIL rstmid_out got ec=%b act=%b exp 0", ec_v, hmove_active);
    end
    for (int i = 0; i < 5; i++) obs_tot[i] = 0;
    for (int t = 0; t < 10; t++) tick();
    sum = 0;
    for (int i = 0; i < 5; i++) sum += obs_tot[i];
    checks++;
    if (sum !== 0) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=0", sum); end
    checks++;
    if (hmove_active !== 1'b0) begin failures++; $display("FAIL rstmid_active got=%b exp=0", hmove_active); end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL rstmid_cycle mismatches=%0d exp=0", mism); end
  endtask

  task automatic test_random();
    logic [4:0] w;
    clear_tot();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++) w[i] = ($urandom_range(0, 9) == 0);
      step(w, 4'($urandom), ($urandom_range(0, 59) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 399) == 0));
    end
    idle(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_tot[i] !== exp_tot[i]) begin
        failures++;
        $display("FAIL rand_count obj=%0d got=%0d exp=%0d", i, obs_tot[i], exp_tot[i]);
      end
    end
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL rand_cycle mismatches=%0d exp=0", mism); end
  endtask

`ifdef TIA_HMOVE_BLANK_EN
  task automatic test_blank();
    clear_tot();
    idle(2);
    hmove();
    checks++;
    if (hmove_blank !== 1'b1) begin failures++; $display("FAIL blank_set got=%b exp=1", hmove_blank); end
    tick();
    checks++;
    if (hmove_blank !== 1'b1) begin failures++; $display("FAIL blank_tick1 got=%b exp=1", hmove_blank); end
    tick();
    checks++;
    if (hmove_blank !== 1'b0) begin failures++; $display("FAIL blank_tick2 got=%b exp=0", hmove_blank); end
    for (int t = 0; t < 13; t++) tick();
    idle(2);
    checks++;
    if (mism !== 0) begin failures++; $display("FAIL blank_cycle mismatches=%0d exp=0", mism); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 5; i++) begin hm_m[i] = 4'd0; stop_m[i] = 1'b0; end
    clear_tot();
    test_reset();
    test_all_zero();
    test_extremes();
    test_hmclr_mid();
    test_restart();
    test_reset_mid();
`ifdef TIA_HMOVE_BLANK_EN
    test_blank();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tia_horizontal_motion.md
TIA_HORIZONTAL_MOTION -- requirements
Module: tia_horizontal_motion

Interface
REQ-001: The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002: phi2  input  1  clock; all state updates on its rising edge.
REQ-003: reset  input  1  synchronous active-high reset.
REQ-004: d  input  4  data bus bits D7..D4 holding the motion value, valid in any cycle where a write strobe is high.
REQ-005: p0hm, p1hm, m0hm, m1hm, blhm  input  1 each  one-cycle write strobes from the write-address decoder, one per object.
REQ-006: hmove  input  1  one-cycle strobe that starts a motion sequence.
REQ-007: hmclr  input  1  one-cycle strobe that clears all motion registers.
REQ-008: mot_tick  input  1  one-cycle motion tick, one per 4 colour clocks, from the horizontal counter.
REQ-009: p0ec, p1ec, m0ec, m1ec, blec  output  1 each  registered one-cycle extra-clock pulses to the object position counters.
REQ-010: hmove_active  output  1  high while a motion sequence runs.

Function
REQ-011: Each object SHALL hold a 4-bit two's-complement motion register hm[i] (range -8..+7).
REQ-012: A strobe on an object's write input SHALL load d into that object's hm[i] on the same edge.
REQ-013: hmclr SHALL clear all five hm[i] to 0; when hmclr and a write strobe coincide, hmclr SHALL win.
REQ-014: The state machine SHALL have two states: IDLE and RUN.
REQ-015: hmove in any state SHALL load the 4-bit counter cnt with 15, set all five per-object enables, and enter RUN; an hmove during RUN SHALL restart the sequence.
REQ-016: In RUN, on each mot_tick, for each object: if cnt == ~(hm[i] ^ 4'b1000), its enable SHALL clear and no pulse SHALL be issued; otherwise, if its enable is set, its ec output SHALL pulse high for exactly one cycle, in the cycle after the tick.
REQ-017: Net effect: each object SHALL receive exactly N = (hm[i] ^ 8) pulses, unsigned 0..15, on ticks 1..N of the sequence (hm=-8 gives 0 pulses, hm=0 gives 8, hm=+7 gives 15).
REQ-018: cnt SHALL decrement on each RUN mot_tick; the tick processed at cnt==1 is the 15th tick, after which the state SHALL return to IDLE and cnt SHALL return to 0.
REQ-019: Comparisons SHALL use the live hm[i], so a write or hmclr during RUN affects the compare from the next tick onward.
REQ-020: hmove coinciding with mot_tick SHALL take priority; that tick SHALL be ignored.
REQ-021: mot_tick in IDLE SHALL have no effect; ec outputs SHALL be low in IDLE.
REQ-022: hmove_active SHALL be high exactly while the state is RUN.

Reset
REQ-023: On reset, hm[i]=0, cnt=0, all enables=0, state=IDLE, and all ec outputs, hmove_active and hmove_blank SHALL be 0 on the next edge.
REQ-024: Reset SHALL override every strobe in the same cycle, including mid-sequence.

Configuration
REQ-025: Macro TIA_HMOVE_BLANK_EN SHALL, when defined, add output hmove_blank (1 bit).
REQ-026: hmove_blank SHALL be set on the edge after hmove and cleared on the edge after the 2nd subsequent mot_tick (8-pixel late-HBLANK comb); a new hmove SHALL restart it.
REQ-027: Without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-028: Shared package tia_pkg SHALL hold HM_W=4, NUM_OBJ=5, HM_SEQ_LEN=15, and the object index enum P0, P1, M0, M1, BL.
REQ-029: Sub-module tia_motion_compare SHALL hold the per-object enable flag, comparator and pulse register; it SHALL be instantiated five times.

Verification
REQ-030: Reset, then hmove followed by 15 mot_ticks with all hm=0 -> 8 pulses on each ec output, and hmove_active falls after the 15th tick.
REQ-031: Write p0hm d=4'b0111 (+7) and m1hm d=4'b1000 (-8), then hmove plus 15 ticks -> p0ec 15 pulses, m1ec 0 pulses, others 8.
REQ-032: Set hm=+7 and run an hmove sequence; after 5 ticks, hmclr -> p0ec total 8 pulses.
REQ-033: hmove at tick 6, then hmove again -> cnt reloads to 15 and the new sequence runs 15 more ticks; hmove coinciding with mot_tick -> that tick produces no pulse.
REQ-034: Assert reset at tick 3 of a sequence -> all outputs 0 next cycle, and later ticks produce no pulses.
REQ-035: With TIA_HMOVE_BLANK_EN defined, hmove then 2 ticks -> hmove_blank high from the cycle after hmove until the cycle after the 2nd tick.
